// File: rtl/xbus_sdram_pkg.sv
// Shared types and constants for the Xbus-to-SDRAM initiator.
package xbus_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_HOLD = 2'd1,
        WR_HOLD = 2'd2,
        RELEASE = 2'd3
    } sdram_state_e;

    localparam logic [21:0] ADDR_LIMIT_DEFAULT = 22'h3C0000;
    localparam logic [31:0] RDATA_ERR          = 32'hFFFF_FFFF;

endpackage

// File: rtl/xbus_sdram_initiator_timer.sv
// Guard and timeout down-counters for a held sdram strobe.
// The timeout half exists only when XBUS_SDRAM_TIMEOUT_EN is defined.
module sdram_hold_timer #(
    parameter int GUARD_CYC = 4
`ifdef XBUS_SDRAM_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic cpu_clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic guard_met
`ifdef XBUS_SDRAM_TIMEOUT_EN
    , output logic expired
`endif
);

    localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

    logic [GW-1:0] guard_cnt;

    // Loaded at accept; reaches zero after GUARD_CYC cycles of strobe, then holds.
    always_ff @(posedge cpu_clk) begin
        if (reset || clear) begin
            guard_cnt <= GW'(GUARD_CYC);
        end else if (run && guard_cnt != '0) begin
            guard_cnt <= guard_cnt - GW'(1);
        end
    end

    assign guard_met = (guard_cnt == '0);

`ifdef XBUS_SDRAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] timeout_cnt;

    always_ff @(posedge cpu_clk) begin
        if (reset || clear) begin
            timeout_cnt <= TW'(TIMEOUT_CYC - 1);
        end else if (run && timeout_cnt != '0) begin
            timeout_cnt <= timeout_cnt - TW'(1);
        end
    end

    assign expired = (timeout_cnt == '0);
`endif

endmodule

// File: rtl/xbus_sdram_initiator.sv
// Xbus initiator for the CADR sdram request/ready handshake, cpu_clk domain.
// Optional strobe timeout abort enabled by defining XBUS_SDRAM_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | no strobe; waiting for an armed, decoded Xbus request
//   RD_HOLD | sdram_req held until guarded sdram_ready
//   WR_HOLD | sdram_write held until guarded sdram_done
//   RELEASE | strobes low; waiting for ready/done to clear
module xbus_sdram_initiator
    import xbus_sdram_pkg::*;
#(
    parameter logic [21:0] ADDR_LIMIT  = ADDR_LIMIT_DEFAULT,
    parameter int          GUARD_CYC   = 4,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [21:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_req,
    input  logic        bus_write,
    output logic        bus_decode,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        bus_err,
    output logic [21:0] sdram_addr,
    output logic [31:0] sdram_data_out,
    input  logic [31:0] sdram_data_in,
    output logic        sdram_req,
    output logic        sdram_write,
    input  logic        sdram_ready,
    input  logic        sdram_done
);

    sdram_state_e state, state_nxt;
    logic         armed, armed_nxt;
    logic [21:0]  addr_nxt;
    logic [31:0]  data_out_nxt;
    logic [31:0]  rdata_nxt;
    logic         req_nxt, write_nxt, ack_nxt;
    logic         timer_clear, timer_run, guard_met;

    assign bus_decode = (bus_addr < ADDR_LIMIT);

`ifdef XBUS_SDRAM_TIMEOUT_EN
    logic expired;
    logic err_nxt;

    sdram_hold_timer #(
        .GUARD_CYC  (GUARD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .clear    (timer_clear),
        .run      (timer_run),
        .guard_met(guard_met),
        .expired  (expired)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) bus_err <= 1'b0;
        else       bus_err <= err_nxt;
    end
`else
    // Timeout length only matters when the abort path is built.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    sdram_hold_timer #(
        .GUARD_CYC(GUARD_CYC)
    ) u_timer (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .clear    (timer_clear),
        .run      (timer_run),
        .guard_met(guard_met)
    );

    assign bus_err = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b1;
            sdram_addr     <= '0;
            sdram_data_out <= '0;
            sdram_req      <= 1'b0;
            sdram_write    <= 1'b0;
            bus_ack        <= 1'b0;
            bus_rdata      <= RDATA_ERR;
        end else begin
            state          <= state_nxt;
            armed          <= armed_nxt;
            sdram_addr     <= addr_nxt;
            sdram_data_out <= data_out_nxt;
            sdram_req      <= req_nxt;
            sdram_write    <= write_nxt;
            bus_ack        <= ack_nxt;
            bus_rdata      <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        armed_nxt    = (!bus_req && !bus_write) ? 1'b1 : armed;
        addr_nxt     = sdram_addr;
        data_out_nxt = sdram_data_out;
        rdata_nxt    = bus_rdata;
        req_nxt      = sdram_req;
        write_nxt    = sdram_write;
        ack_nxt      = 1'b0;
        timer_clear  = 1'b0;
        timer_run    = 1'b0;
`ifdef XBUS_SDRAM_TIMEOUT_EN
        err_nxt      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (armed && bus_decode && (bus_req || bus_write)) begin
                    addr_nxt     = bus_addr;
                    data_out_nxt = bus_wdata;
                    timer_clear  = 1'b1;
                    if (bus_req) begin
                        req_nxt   = 1'b1;
                        state_nxt = RD_HOLD;
                    end else begin
                        write_nxt = 1'b1;
                        state_nxt = WR_HOLD;
                    end
                end
            end
            RD_HOLD: begin
                timer_run = 1'b1;
                // Completion beats expiry when both land on the same cycle.
                if (guard_met && sdram_ready) begin
                    rdata_nxt = sdram_data_in;
                    req_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
`ifdef XBUS_SDRAM_TIMEOUT_EN
                else if (expired) begin
                    rdata_nxt = RDATA_ERR;
                    req_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
`endif
            end
            WR_HOLD: begin
                timer_run = 1'b1;
                if (guard_met && sdram_done) begin
                    write_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
`ifdef XBUS_SDRAM_TIMEOUT_EN
                else if (expired) begin
                    write_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!sdram_ready && !sdram_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_xbus_sdram_initiator.sv
// Scoreboard bench for xbus_sdram_initiator; covers the timeout abort when XBUS_SDRAM_TIMEOUT_EN is defined.
module tb_xbus_sdram_initiator;

    localparam int GUARD   = 4;
    localparam int TIMEOUT = 1024;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [21:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_req, bus_write;
    logic        bus_decode;
    logic [31:0] bus_rdata;
    logic        bus_ack, bus_err;
    logic [21:0] sdram_addr;
    logic [31:0] sdram_data_out, sdram_data_in;
    logic        sdram_req, sdram_write, sdram_ready, sdram_done;

    always #5 cpu_clk = ~cpu_clk;

    xbus_sdram_initiator #(
        .ADDR_LIMIT (22'h3C0000),
        .GUARD_CYC  (GUARD),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .cpu_clk       (cpu_clk),
        .reset         (reset),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_req       (bus_req),
        .bus_write     (bus_write),
        .bus_decode    (bus_decode),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .bus_err       (bus_err),
        .sdram_addr    (sdram_addr),
        .sdram_data_out(sdram_data_out),
        .sdram_data_in (sdram_data_in),
        .sdram_req     (sdram_req),
        .sdram_write   (sdram_write),
        .sdram_ready   (sdram_ready),
        .sdram_done    (sdram_done)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = 32'hFFFF_FFFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every ack consumes one expected completion.
    always @(negedge cpu_clk) begin
        if (bus_ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(bus_ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", bus_rdata, mon_e.rdata);
                check("err", 32'(bus_err), 32'(mon_e.err));
            end
        end
        if (bus_err && !bus_ack) check("err_without_ack", 32'(bus_err), 32'd0);
        if (sdram_req && sdram_write) check("strobe_excl", 32'(sdram_write), 32'd0);
    end

    // Drives one transaction from the negedge the task is entered on; ready/done
    // is stale for cycles [0, stale_n) and real from resp_at until ack.
    task automatic run_xfer(input bit is_read, input bit both, input logic [21:0] addr,
                            input logic [31:0] data, input int stale_n, input int resp_at,
                            input bit silent, input int hold_after);
        int   exp_ack;
        bit   lvl;
        exp_t e;
        if (silent) exp_ack = TIMEOUT + 1;
        else        exp_ack = (resp_at + 1 > GUARD + 2) ? resp_at + 1 : GUARD + 2;
        bus_addr      = addr;
        bus_wdata     = data;
        sdram_data_in = data;
        bus_req       = is_read || both;
        bus_write     = !is_read || both;
        sdram_ready   = is_read && (stale_n > 0);
        sdram_done    = !is_read && (stale_n > 0);
        if (silent)       exp_rdata = 32'hFFFF_FFFF;
        else if (is_read) exp_rdata = data;
        e.err   = silent;
        e.rdata = exp_rdata;
        sb.push_back(e);
        for (int i = 1; i <= exp_ack; i++) begin
            @(negedge cpu_clk);
            if (i < exp_ack) begin
                check("strobe", 32'({sdram_write, sdram_req}), is_read ? 32'd1 : 32'd2);
                check("addr", 32'(sdram_addr), 32'(addr));
                if (!is_read) check("wdata", sdram_data_out, data);
                check("no_early_ack", 32'(bus_ack), 32'd0);
            end else begin
                check("ack", 32'(bus_ack), 32'd1);
                check("strobe_drop", 32'({sdram_write, sdram_req}), 32'd0);
            end
            lvl = (i < stale_n) || (!silent && i >= resp_at && i < exp_ack);
            sdram_ready = is_read && lvl;
            sdram_done  = !is_read && lvl;
            if (i == exp_ack && hold_after == 0) begin
                bus_req   = 1'b0;
                bus_write = 1'b0;
            end
        end
        for (int j = 0; j < hold_after; j++) begin
            @(negedge cpu_clk);
            check("no_reissue", 32'({sdram_write, sdram_req}), 32'd0);
        end
        bus_req   = 1'b0;
        bus_write = 1'b0;
        repeat (2) @(negedge cpu_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus_addr      = '0;
        bus_wdata     = '0;
        bus_req       = 1'b0;
        bus_write     = 1'b0;
        sdram_data_in = '0;
        sdram_ready   = 1'b0;
        sdram_done    = 1'b0;
        repeat (3) @(negedge cpu_clk);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_write", 32'(sdram_write), 32'd0);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_rdata", bus_rdata, 32'hFFFF_FFFF);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        reset = 1'b0;
        @(negedge cpu_clk);

        run_xfer(1'b1, 1'b0, 22'h001234, 32'hDEAD_BEEF, 0, 6, 1'b0, 0);
        run_xfer(1'b1, 1'b0, 22'h000400, 32'h1234_5678, 3, 8, 1'b0, 0);
        run_xfer(1'b1, 1'b0, 22'h00002A, 32'hCAFE_F00D, 0, 1, 1'b0, 0);
        run_xfer(1'b0, 1'b0, 22'h3BFFFF, 32'hA5A5_A5A5, 0, 6, 1'b0, 0);

        bus_addr  = 22'h3C0000;
        bus_wdata = 32'hA5A5_A5A5;
        bus_write = 1'b1;
        #1;
        check("decode_oor", 32'(bus_decode), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            check("oor_no_strobe", 32'({sdram_write, sdram_req}), 32'd0);
        end
        bus_write = 1'b0;
        bus_addr  = 22'h3BFFFF;
        #1;
        check("decode_edge", 32'(bus_decode), 32'd1);
        @(negedge cpu_clk);

        run_xfer(1'b1, 1'b1, 22'h000055, 32'h0BAD_CAFE, 0, 5, 1'b0, 0);
        run_xfer(1'b1, 1'b0, 22'h000077, 32'h1357_9BDF, 0, 7, 1'b0, 20);
        run_xfer(1'b1, 1'b0, 22'h000078, 32'h2468_ACE0, 0, 9, 1'b0, 0);
        run_xfer(1'b0, 1'b0, 22'h000010, 32'h5A5A_0F0F, 2, 4, 1'b0, 0);
`ifdef XBUS_SDRAM_TIMEOUT_EN
        run_xfer(1'b1, 1'b0, 22'h000099, 32'h1111_2222, 0, 0, 1'b1, 0);
`endif

        bus_addr = 22'h000100;
        bus_req  = 1'b1;
        @(negedge cpu_clk);
        check("rst_test_strobe", 32'(sdram_req), 32'd1);
        repeat (2) @(negedge cpu_clk);
        reset = 1'b1;
        @(negedge cpu_clk);
        check("midrst_req", 32'(sdram_req), 32'd0);
        check("midrst_ack", 32'(bus_ack), 32'd0);
        check("midrst_rdata", bus_rdata, 32'hFFFF_FFFF);
        reset   = 1'b0;
        bus_req = 1'b0;
        repeat (3) @(negedge cpu_clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
